sccb_bus_arbiter: RTL and testbench
===================================

Name: sccb_bus_arbiter

Overview:
- Shares one byte-level SCCB/I2C master between two requesters:
  - Port 0 is the OV5640 power-up register-table sequencer.
  - Port 1 is the runtime register client (exposure/gain/AWB tweaks, register reads).
- During the configuration phase (cfg_done low), only port 0 is served. Afterwards the two ports are served round-robin.
- Enforces an inter-transaction bus-free gap and returns read data and completion to the winning requester.

Parameters:
- ADDR_W, 16, register address width (OV5640 16-bit sub-address)
- DATA_W, 8, register data width
- GAP_CYCLES, 10, idle clocks between consecutive master transactions (min 1)
- TIMEOUT, 100000, clocks allowed for i2c_done after launch (used only with the optional feature)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cfg_done  in  1  high once the power-up table is complete; low restricts grants to port 0
- m0_req  in  1  port 0 request, level, held until m0_ack
- m0_wr  in  1  1 = write, 0 = read
- m0_addr  in  ADDR_W  register address
- m0_wdata  in  DATA_W  write data
- m0_ack  out  1  one-cycle completion pulse
- m0_err  out  1  valid with m0_ack; 1 = transaction timed out
- m0_rdata  out  DATA_W  read data, valid with m0_ack, held until next port 0 ack
- m1_req, m1_wr, m1_addr, m1_wdata, m1_ack, m1_err, m1_rdata: same as port 0, for port 1
- i2c_req  out  1  one-cycle launch pulse to the master
- i2c_wr  out  1  command to master, registered, stable IDLE→GAP
- i2c_addr  out  ADDR_W  registered, stable from launch until done
- i2c_wdata  out  DATA_W  registered, stable from launch until done
- i2c_done  in  1  one-cycle completion pulse from the master
- i2c_rdata  in  DATA_W  master read data, valid with i2c_done
- i2c_abort  out  1  one-cycle abort pulse to the master (timeout only)
- busy  out  1  high in every state except IDLE
- grant  out  1  index of the currently or last granted port

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE.
  - All outputs are 0, including rdata registers and grant.
  - Round-robin pointer last = 1, so port 0 wins the first tie.
  - Reset mid-transaction abandons it; no ack is issued.
- States: IDLE, LAUNCH, WAIT, ACK, GAP.
- IDLE:
  - cfg_done = 0: only m0_req is eligible; m1_req is ignored and stays pending.
  - cfg_done = 1: if both requests are asserted, grant the port ≠ last; otherwise grant whichever is asserted.
  - On a grant: latch the winner's wr/addr/wdata into the i2c_* registers, set grant, set last = winner, and go to LAUNCH.
- LAUNCH: i2c_req = 1 for exactly this cycle, then WAIT. Latency from req sampled in IDLE to i2c_req high is 1 clock.
- WAIT:
  - Hold the i2c_* outputs.
  - On i2c_done: capture i2c_rdata into the winner's rdata (reads only; writes leave rdata unchanged), then go to ACK.
  - An i2c_done in any state other than WAIT is ignored.
- ACK:
  - The winner's mX_ack = 1 for one cycle; mX_err = 0.
  - Then GAP with the counter loaded to GAP_CYCLES-1.
- GAP:
  - Count down; all requests are ignored.
  - At 0, go to IDLE. A request still high then counts as a new transaction, so requesters must drop req on the edge they sample ack.
- A requester that drops req during WAIT does not cancel the transaction; ack still pulses.
- cfg_done falling during a port 1 transaction: that transaction completes normally; the restriction applies at the next IDLE.
- i2c_done arriving in the same cycle as LAUNCH is not possible (the master has at least 1 cycle latency); if it occurs, it is ignored.
- busy = (state ≠ IDLE), registered with the state.

Optional Feature:
- Macro: SCCB_ARB_TIMEOUT_EN.
- Defined:
  - A WAIT cycle counter is cleared on entering WAIT.
  - If it reaches TIMEOUT-1 with no i2c_done: pulse i2c_abort for one cycle and go to ACK.
  - In that ACK, mX_ack = 1 and mX_err = 1, and mX_rdata is left unchanged.
  - GAP then applies as normal.
- Not defined:
  - No counter is built; WAIT waits indefinitely.
  - i2c_abort and m0_err/m1_err are tied to 0.
  - TIMEOUT is unused.

Test Plan:
- Reset, cfg_done = 0, m0 write addr 0x3008 data 0x82; master done after 30 clk → i2c_req 1 clk after req, i2c_addr = 0x3008, i2c_wdata = 0x82, i2c_wr = 1, m0_ack 1 clk after i2c_done, m0_err = 0.
- cfg_done = 0, m1_req and m0_req both high → m0 granted for every transaction; m1 stays pending; once cfg_done = 1 after m0's ack, m1 is granted at the next IDLE.
- cfg_done = 1, both requests held continuously → grants alternate 0,1,0,1; the gap between i2c_done and the next i2c_req is ≥ GAP_CYCLES+2 clk.
- m1 read addr 0x300A; master returns 0x56 → m1_rdata = 0x56 with m1_ack; m0_rdata unchanged.
- With SCCB_ARB_TIMEOUT_EN and TIMEOUT = 10, master never sends done → i2c_abort at WAIT cycle 10, m0_ack = 1 with m0_err = 1, return to IDLE after GAP.
- Assert rst_n low during WAIT, then release → no ack, all outputs 0, next request to port 0 is served normally.

Source files
------------

// File: rtl/sccb_bus_arbiter.sv
// Two-port arbiter in front of one byte-level SCCB/I2C master: port 0 only while
// configuring, round-robin afterwards. Define SCCB_ARB_TIMEOUT_EN for the WAIT timeout/abort.
module sccb_bus_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int GAP_CYCLES = 10,
    parameter int TIMEOUT    = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_done,
    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic              m0_err,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic              m1_err,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              i2c_req,
    output logic              i2c_wr,
    output logic [ADDR_W-1:0] i2c_addr,
    output logic [DATA_W-1:0] i2c_wdata,
    input  logic              i2c_done,
    input  logic [DATA_W-1:0] i2c_rdata,
    output logic              i2c_abort,
    output logic              busy,
    output logic              grant
);

    typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_ACK, S_GAP} state_t;

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    state_t             state;
    logic               last;
    logic [GAP_W-1:0]   gap_cnt;
    logic               win_valid;
    logic               win_port;
    logic               timeout_now;

    // Port 1 is invisible until the power-up table is done; a tie goes to the port not served last.
    // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        win_valid = m0_req | (cfg_done & m1_req);
        if (m0_req && cfg_done && m1_req)
            win_port = ~last;
        else
            win_port = ~m0_req;
    end

`ifdef SCCB_ARB_TIMEOUT_EN
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [WAIT_W-1:0]  wait_cnt;
    logic               timeout_q;

    // The counter idles at zero outside WAIT, so it is already cleared on entry.
    assign timeout_now = (state == S_WAIT) && !i2c_done &&
                         (wait_cnt == WAIT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_now;
            if (state == S_WAIT)
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;
        end
    end

    // timeout_q is high exactly during the ACK cycle that follows an abort.
    assign i2c_abort = timeout_q;
    assign m0_err    = timeout_q & m0_ack;
    assign m1_err    = timeout_q & m1_ack;
`else
    assign timeout_now = 1'b0;
    assign i2c_abort   = 1'b0;
    assign m0_err      = 1'b0;
    assign m1_err      = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the read-data holding registers are reset too, so both ports read 0 after reset.
            state     <= S_IDLE;
            last      <= 1'b1;
            grant     <= 1'b0;
            busy      <= 1'b0;
            gap_cnt   <= '0;
            i2c_req   <= 1'b0;
            i2c_wr    <= 1'b0;
            i2c_addr  <= '0;
            i2c_wdata <= '0;
            m0_ack    <= 1'b0;
            m1_ack    <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (win_valid) begin
                        grant     <= win_port;
                        last      <= win_port;
                        i2c_wr    <= win_port ? m1_wr    : m0_wr;
                        i2c_addr  <= win_port ? m1_addr  : m0_addr;
                        i2c_wdata <= win_port ? m1_wdata : m0_wdata;
                        i2c_req   <= 1'b1;
                        busy      <= 1'b1;
                        state     <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    // A done seen here is not a real completion and is dropped.
                    i2c_req <= 1'b0;
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (i2c_done) begin
                        if (!i2c_wr) begin
                            if (grant)
                                m1_rdata <= i2c_rdata;
                            else
                                m0_rdata <= i2c_rdata;
                        end
                        m0_ack <= ~grant;
                        m1_ack <= grant;
                        state  <= S_ACK;
                    end else if (timeout_now) begin
                        m0_ack <= ~grant;
                        m1_ack <= grant;
                        state  <= S_ACK;
                    end
                end
                S_ACK: begin
                    m0_ack  <= 1'b0;
                    m1_ack  <= 1'b0;
                    gap_cnt <= GAP_W'(GAP_CYCLES - 1);
                    state   <= S_GAP;
                end
                S_GAP: begin
                    if (gap_cnt == '0) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sccb_bus_arbiter.sv
// Self-checking bench for sccb_bus_arbiter: vector table, scoreboard queues and a
// behavioural master; the timeout sequence runs only when SCCB_ARB_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_sccb_bus_arbiter;

    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 8;
    localparam int GAP_CYCLES = 10;
    localparam int TB_TIMEOUT = 10;
`ifdef SCCB_ARB_TIMEOUT_EN
    localparam int MAX_LAT    = TB_TIMEOUT - 1;
    localparam int EXP_ABORTS = 1;
`else
    localparam int MAX_LAT    = 1000;
    localparam int EXP_ABORTS = 0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cfg_done;
    logic              m0_req, m0_wr, m0_ack, m0_err;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata, m0_rdata;
    logic              m1_req, m1_wr, m1_ack, m1_err;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata, m1_rdata;
    logic              i2c_req, i2c_wr, i2c_done, i2c_abort, busy, grant;
    logic [ADDR_W-1:0] i2c_addr;
    logic [DATA_W-1:0] i2c_wdata, i2c_rdata;

    sccb_bus_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .GAP_CYCLES(GAP_CYCLES), .TIMEOUT(TB_TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_done(cfg_done),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .i2c_req(i2c_req), .i2c_wr(i2c_wr), .i2c_addr(i2c_addr), .i2c_wdata(i2c_wdata),
        .i2c_done(i2c_done), .i2c_rdata(i2c_rdata), .i2c_abort(i2c_abort),
        .busy(busy), .grant(grant)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              port;
        logic              wr;
        logic              cfg;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] mrd;
        int                lat;
    } vec_t;

    typedef struct {
        logic              port;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } launch_t;

    typedef struct {
        logic              port;
        logic              err;
        logic [DATA_W-1:0] rd0;
        logic [DATA_W-1:0] rd1;
    } ack_t;

    typedef struct {
        int                lat;
        logic [DATA_W-1:0] rd;
    } serve_t;

    launch_t           launch_q[$];
    ack_t              ack_q[$];
    serve_t            serve_q[$];
    logic [DATA_W-1:0] model_rd[2];

    int cyc = 0;
    int done_cyc = -1000;
    int launch_cyc = 0;
    int abort_cnt = 0;
    int n_checks = 0;
    int n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // mode 0: served normally, 1: master stays silent (timeout), 2: abandoned by reset
    task automatic push_txn(input logic port, input logic wr, input logic [ADDR_W-1:0] addr,
                            input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] mrd,
                            input int lat, input int mode);
        launch_t l;
        serve_t  s;
        ack_t    a;
        l.port = port; l.wr = wr; l.addr = addr; l.wdata = wdata;
        launch_q.push_back(l);
        if (mode == 0) begin
            s.lat = lat; s.rd = mrd;
            serve_q.push_back(s);
            if (!wr) model_rd[port] = mrd;
        end
        if (mode != 2) begin
            a.port = port; a.err = (mode == 1); a.rd0 = model_rd[0]; a.rd1 = model_rd[1];
            ack_q.push_back(a);
        end
    endtask

    task automatic drive_port(input logic port, input logic req, input logic wr,
                              input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
        if (port) begin
            m1_req = req; m1_wr = wr; m1_addr = addr; m1_wdata = wdata;
        end else begin
            m0_req = req; m0_wr = wr; m0_addr = addr; m0_wdata = wdata;
        end
    endtask

    task automatic wait_idle();
        logic ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(posedge clk); #1;
            ok = !busy;
        end
        check("idle_reached", ok, 1'b1);
    endtask

    task automatic wait_launch(output logic seen);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge clk); #1;
            seen = i2c_req;
        end
    endtask

    task automatic wait_ack(input logic port, input int budget, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk); #1;
            seen = port ? m1_ack : m0_ack;
        end
    endtask

    task automatic do_txn(input vec_t v);
        int   lat;
        int   c0;
        logic seen;
        lat = (v.lat > MAX_LAT) ? MAX_LAT : v.lat;
        wait_idle();
        cfg_done = v.cfg;
        drive_port(v.port, 1'b1, v.wr, v.addr, v.wdata);
        push_txn(v.port, v.wr, v.addr, v.wdata, v.mrd, lat, 0);
        c0 = cyc;
        wait_launch(seen);
        check("launch_seen", seen, 1'b1);
        check("launch_latency", cyc - c0, 1);
        wait_ack(v.port, lat + 10, seen);
        check("ack_seen", seen, 1'b1);
        drive_port(v.port, 1'b0, v.wr, v.addr, v.wdata);
    endtask

    task automatic check_reset_outputs();
        check("rst_i2c_req", i2c_req, 0);     check("rst_i2c_wr", i2c_wr, 0);
        check("rst_i2c_addr", i2c_addr, 0);   check("rst_i2c_wdata", i2c_wdata, 0);
        check("rst_i2c_abort", i2c_abort, 0); check("rst_busy", busy, 0);
        check("rst_grant", grant, 0);         check("rst_m0_ack", m0_ack, 0);
        check("rst_m1_ack", m1_ack, 0);       check("rst_m0_err", m0_err, 0);
        check("rst_m1_err", m1_err, 0);       check("rst_m0_rdata", m0_rdata, 0);
        check("rst_m1_rdata", m1_rdata, 0);
    endtask

    // Behavioural master: answers each launch that has a queued response after its latency.
    initial begin
        serve_t s;
        i2c_done = 1'b0;
        i2c_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (i2c_req && serve_q.size() > 0) begin
                s = serve_q.pop_front();
                repeat (s.lat) @(posedge clk);
                #1;
                i2c_done = 1'b1;
                i2c_rdata = s.rd;
                done_cyc = cyc;
                @(posedge clk); #1;
                i2c_done = 1'b0;
            end
        end
    end

    // Scoreboard monitors sample on the falling edge.
    always @(negedge clk) begin
        launch_t l;
        ack_t    a;
        if (rst_n) begin
            if (i2c_req) begin
                check("launch_expected", launch_q.size() > 0, 1'b1);
                if (launch_q.size() > 0) begin
                    l = launch_q.pop_front();
                    check("launch_grant", grant, l.port);
                    check("launch_wr", i2c_wr, l.wr);
                    check("launch_addr", i2c_addr, l.addr);
                    check("launch_wdata", i2c_wdata, l.wdata);
                    check("launch_busy", busy, 1'b1);
                end
                check("bus_free_gap", (cyc - done_cyc) >= GAP_CYCLES + 2, 1'b1);
                launch_cyc = cyc;
            end
            if (i2c_abort) begin
                abort_cnt++;
                check("abort_time", cyc - launch_cyc, TB_TIMEOUT + 1);
            end
            if (m0_ack || m1_ack) begin
                check("single_ack", m0_ack & m1_ack, 1'b0);
                check("ack_expected", ack_q.size() > 0, 1'b1);
                if (ack_q.size() > 0) begin
                    a = ack_q.pop_front();
                    check("ack_port", m1_ack, a.port);
                    check("ack_err", m0_err | m1_err, a.err);
                    check("m0_rdata", m0_rdata, a.rd0);
                    check("m1_rdata", m1_rdata, a.rd1);
                    if (!a.err) check("ack_latency", cyc - done_cyc, 1);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t vecs[6];
        logic seen;
        vecs[0] = '{port: 1'b0, wr: 1'b1, cfg: 1'b0, addr: 16'h3008, wdata: 8'h82, mrd: 8'h00, lat: 30};
        vecs[1] = '{port: 1'b0, wr: 1'b0, cfg: 1'b0, addr: 16'h300B, wdata: 8'h00, mrd: 8'h4C, lat: 3};
        vecs[2] = '{port: 1'b1, wr: 1'b0, cfg: 1'b1, addr: 16'h300A, wdata: 8'h00, mrd: 8'h56, lat: 5};
        vecs[3] = '{port: 1'b1, wr: 1'b1, cfg: 1'b1, addr: 16'h3500, wdata: 8'h12, mrd: 8'hEE, lat: 1};
        vecs[4] = '{port: 1'b0, wr: 1'b1, cfg: 1'b1, addr: 16'h3503, wdata: 8'h07, mrd: 8'hDD, lat: 2};
        vecs[5] = '{port: 1'b1, wr: 1'b0, cfg: 1'b1, addr: 16'h5001, wdata: 8'h00, mrd: 8'hA5, lat: 7};

        model_rd[0] = '0;
        model_rd[1] = '0;
        rst_n = 1'b0;
        cfg_done = 1'b0;
        drive_port(1'b0, 1'b0, 1'b0, '0, '0);
        drive_port(1'b1, 1'b0, 1'b0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) do_txn(vecs[i]);

        // Configuration phase: port 1 stays pending while port 0 is re-served.
        wait_idle();
        cfg_done = 1'b0;
        drive_port(1'b1, 1'b1, 1'b0, 16'h300A, 8'h00);
        drive_port(1'b0, 1'b1, 1'b1, 16'h3103, 8'h03);
        push_txn(1'b0, 1'b1, 16'h3103, 8'h03, 8'h00, 4, 0);
        push_txn(1'b0, 1'b1, 16'h3103, 8'h03, 8'h00, 4, 0);
        push_txn(1'b1, 1'b0, 16'h300A, 8'h00, 8'h3C, 4, 0);
        wait_ack(1'b0, 60, seen);
        check("cfg_m0_ack1", seen, 1'b1);
        wait_ack(1'b0, 60, seen);
        check("cfg_m0_ack2", seen, 1'b1);
        m0_req = 1'b0;
        cfg_done = 1'b1;
        wait_ack(1'b1, 60, seen);
        check("cfg_m1_ack", seen, 1'b1);
        m1_req = 1'b0;

        // Both held: grants alternate 0,1,0,1.
        wait_idle();
        drive_port(1'b0, 1'b1, 1'b1, 16'h3A0F, 8'h30);
        drive_port(1'b1, 1'b1, 1'b0, 16'h3A10, 8'h00);
        push_txn(1'b0, 1'b1, 16'h3A0F, 8'h30, 8'h00, 4, 0);
        push_txn(1'b1, 1'b0, 16'h3A10, 8'h00, 8'h11, 4, 0);
        push_txn(1'b0, 1'b1, 16'h3A0F, 8'h30, 8'h00, 4, 0);
        push_txn(1'b1, 1'b0, 16'h3A10, 8'h00, 8'h22, 4, 0);
        wait_ack(1'b1, 60, seen);
        check("rr_m1_ack1", seen, 1'b1);
        wait_ack(1'b1, 60, seen);
        check("rr_m1_ack2", seen, 1'b1);
        m0_req = 1'b0;
        m1_req = 1'b0;

`ifdef SCCB_ARB_TIMEOUT_EN
        // Silent master: abort, ack with err, rdata untouched.
        wait_idle();
        drive_port(1'b0, 1'b1, 1'b1, 16'h3008, 8'h02);
        push_txn(1'b0, 1'b1, 16'h3008, 8'h02, 8'h00, 0, 1);
        wait_ack(1'b0, TB_TIMEOUT + 20, seen);
        check("timeout_ack", seen, 1'b1);
        m0_req = 1'b0;
`endif

        // Reset during WAIT abandons the transaction silently.
        wait_idle();
        drive_port(1'b0, 1'b1, 1'b1, 16'h3A00, 8'h55);
        push_txn(1'b0, 1'b1, 16'h3A00, 8'h55, 8'h00, 0, 2);
        wait_launch(seen);
        check("abandon_launch", seen, 1'b1);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        m0_req = 1'b0;
        #1;
        check_reset_outputs();
        model_rd[0] = '0;
        model_rd[1] = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("no_pending_ack", ack_q.size(), 0);

        do_txn('{port: 1'b0, wr: 1'b0, cfg: 1'b1, addr: 16'h300C, wdata: 8'h00, mrd: 8'h9E, lat: 3});
        wait_idle();

        check("abort_count", abort_cnt, EXP_ABORTS);
        check("launch_q_drained", launch_q.size(), 0);
        check("ack_q_drained", ack_q.size(), 0);
        check("serve_q_drained", serve_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
